sram_ctrl: RTL and testbench

- Responder side of the 32-bit word memory command bus (addr/wrdata/wren/strobe/wait/rddata) driven by the CPU-side cache.
- Executes each word request as four byte accesses on the external 512K x 8 asynchronous SRAM.
- Sits between the cache's memory command master port and the top-level SRAM pins; the top level builds the DQ tristate from the split data pins.

---
 rtl/sram_ctrl.sv | 133 +++++++++++++
 tb/tb_sram_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Purpose: word-bus responder that runs each 32-bit request as four byte cycles on an async 512Kx8 SRAM.
// Latency: read 1+4*(1+ACCESS_CYCLES), write 1+4*(2+ACCESS_CYCLES) cycles from strobe seen in idle to s_wait low.
// Backpressure: s_wait stays high until the single completion cycle; the master holds strobe/addr/data until then.
module sram_ctrl #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [16:0] s_addr,
  input  logic [31:0] s_wrdata,
  input  logic        s_wren,
  input  logic        s_strobe,
  output logic        s_wait,
  output logic [31:0] s_rddata,
  output logic [18:0] sram_a,
  input  logic [7:0]  sram_dq_in,
  output logic [7:0]  sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Access counter reloads to ACCESS_CYCLES-1 and counts down to zero.
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_idx;
  logic [1:0]  idx_nxt;
  logic [3:0]  cnt;
  logic [16:0] addr_q;
  logic [16:0] addr_src;
  logic [31:0] wrdata_q;
  logic        wren_q;

  // Completion is a pure decode of the registered state, so it is high in reset.
  assign s_wait = (state != ST_DONE);

  // Next-state and next byte index; address comes straight from the bus on the accepting cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = byte_idx;
    addr_src  = (state == ST_IDLE) ? s_addr : addr_q;
    case (state)
      ST_IDLE: begin
        if (s_strobe) begin
          state_nxt = ST_SETUP;
          idx_nxt   = 2'd0;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (cnt == 4'd0) begin
          if (wren_q) begin
            state_nxt = ST_HOLD;
          end else if (byte_idx == 2'd3) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_SETUP;
            idx_nxt   = byte_idx + 2'd1;
          end
        end
      end
      ST_HOLD: begin
        if (byte_idx == 2'd3) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETUP;
          idx_nxt   = byte_idx + 2'd1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte sequencer, access counter, request latches and registered pins (pins decoded from the next state).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      byte_idx    <= 2'd0;
      cnt         <= 4'd0;
      addr_q      <= 17'd0;
      wrdata_q    <= 32'd0;
      wren_q      <= 1'b0;
      s_rddata    <= 32'd0;
      sram_a      <= 19'd0;
      sram_dq_out <= 8'd0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
      if (state == ST_IDLE && s_strobe) begin
        addr_q   <= s_addr;
        wrdata_q <= s_wrdata;
        wren_q   <= s_wren;
      end
      if (state == ST_SETUP) begin
        cnt <= CNT_INIT;
      end else if (state == ST_ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Read data is sampled while OE_n is still low at the end of the last access cycle.
      if (state == ST_ACCESS && cnt == 4'd0 && !wren_q) begin
        s_rddata[{byte_idx, 3'b000} +: 8] <= sram_dq_in;
      end
      if (state_nxt == ST_SETUP) begin
        sram_a <= {addr_src, idx_nxt};
      end
      // Write data is loaded entering Access and kept through Hold for data hold time.
      if (state == ST_SETUP && wren_q) begin
        sram_dq_out <= wrdata_q[{byte_idx, 3'b000} +: 8];
      end
      sram_ce_n  <= !(state_nxt == ST_SETUP || state_nxt == ST_ACCESS || state_nxt == ST_HOLD);
      sram_oe_n  <= !(state_nxt == ST_ACCESS && !wren_q);
      sram_we_n  <= !(state_nxt == ST_ACCESS && wren_q);
      sram_dq_oe <= wren_q && (state_nxt == ST_ACCESS || state_nxt == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (ACCESS_CYCLES 2 and 1) each with a behavioural async SRAM.
// Expected read words and latencies are queued when a request is driven and compared at completion.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  logic [16:0] s_addr0, s_addr1;
  logic [31:0] s_wrdata0, s_wrdata1;
  logic        s_wren0, s_wren1, s_strobe0, s_strobe1;
  logic        s_wait0, s_wait1;
  logic [31:0] s_rddata0, s_rddata1;
  logic [18:0] sram_a0, sram_a1;
  logic [7:0]  dq_in0, dq_in1, dq_out0, dq_out1;
  logic        dq_oe0, dq_oe1, ce_n0, ce_n1, oe_n0, oe_n1, we_n0, we_n1;

  logic [7:0] mem0 [0:524287];
  logic [7:0] mem1 [0:524287];

  int checks = 0;
  int errors = 0;
  int ovl0 = 0, ovl1 = 0, rdwe = 0, hold0 = 0;
  logic rd_act0 = 1'b0, rd_act1 = 1'b0;
  logic [18:0] rd_trace [$];
  logic [31:0] exp_rd_q [$];
  int          exp_lat_q [$];

  always #5 clk = ~clk;

  assign dq_in0 = (!ce_n0 && !oe_n0) ? mem0[sram_a0] : 8'hA5;
  assign dq_in1 = (!ce_n1 && !oe_n1) ? mem1[sram_a1] : 8'hA5;

  sram_ctrl #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .s_addr(s_addr0), .s_wrdata(s_wrdata0), .s_wren(s_wren0),
    .s_strobe(s_strobe0), .s_wait(s_wait0), .s_rddata(s_rddata0), .sram_a(sram_a0),
    .sram_dq_in(dq_in0), .sram_dq_out(dq_out0), .sram_dq_oe(dq_oe0), .sram_ce_n(ce_n0),
    .sram_oe_n(oe_n0), .sram_we_n(we_n0)
  );

  sram_ctrl #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_addr(s_addr1), .s_wrdata(s_wrdata1), .s_wren(s_wren1),
    .s_strobe(s_strobe1), .s_wait(s_wait1), .s_rddata(s_rddata1), .sram_a(sram_a1),
    .sram_dq_in(dq_in1), .sram_dq_out(dq_out1), .sram_dq_oe(dq_oe1), .sram_ce_n(ce_n1),
    .sram_oe_n(oe_n1), .sram_we_n(we_n1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request on instance sel starting in the current (idle) cycle; returns in the following idle cycle.
  task automatic run_req(input int sel, input logic wr, input logic [16:0] addr,
                         input logic [31:0] data, input int lat, input logic [31:0] rd);
    int          n;
    logic        w;
    logic [31:0] e_rd;
    int          e_lat;
    exp_rd_q.push_back(rd);
    exp_lat_q.push_back(lat);
    if (sel == 0) begin
      s_addr0 = addr; s_wrdata0 = data; s_wren0 = wr; s_strobe0 = 1'b1; rd_act0 = !wr;
    end else begin
      s_addr1 = addr; s_wrdata1 = data; s_wren1 = wr; s_strobe1 = 1'b1; rd_act1 = !wr;
    end
    n = 0;
    w = 1'b1;
    while (w && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      w = (sel == 0) ? s_wait0 : s_wait1;
    end
    e_rd  = exp_rd_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    if (w) begin
      chk("completion_timeout", 32'(n), 32'(e_lat));
    end else begin
      chk("latency", 32'(n), 32'(e_lat));
      chk("rddata", (sel == 0) ? s_rddata0 : s_rddata1, e_rd);
    end
    if (sel == 0) begin
      s_strobe0 = 1'b0; rd_act0 = 1'b0;
    end else begin
      s_strobe1 = 1'b0; rd_act1 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // SRAM models and pin monitors; a write byte commits when WE_n rises with CE_n low and data still driven.
  initial begin
    logic        pend0, pend1;
    logic [18:0] pa0, pa1;
    logic [7:0]  pd0, pd1;
    pend0 = 1'b0; pend1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 4; i++) begin
      mem0[19'h14 + 19'(i)] = 8'(8'h11 * (i + 1));
      mem0[19'h0C + 19'(i)] = 8'(8'hA0 + i);
      mem1[19'h20 + 19'(i)] = 8'(i + 1);
    end
    forever begin
      @(negedge clk);
      if (!ce_n0 && !we_n0) begin
        pend0 = 1'b1; pa0 = sram_a0; pd0 = dq_out0;
      end else if (pend0) begin
        if (!ce_n0 && dq_oe0) mem0[pa0] = pd0;
        pend0 = 1'b0;
      end
      if (!ce_n1 && !we_n1) begin
        pend1 = 1'b1; pa1 = sram_a1; pd1 = dq_out1;
      end else if (pend1) begin
        if (!ce_n1 && dq_oe1) mem1[pa1] = pd1;
        pend1 = 1'b0;
      end
      if (dq_oe0 && !oe_n0) ovl0++;
      if (dq_oe1 && !oe_n1) ovl1++;
      if ((rd_act0 && !we_n0) || (rd_act1 && !we_n1)) rdwe++;
      if (!ce_n0 && we_n0 && dq_oe0) hold0++;
      if (!oe_n0) rd_trace.push_back(sram_a0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          base;
    int          hbase;
    logic [31:0] wd;
    reset_n = 1'b0;
    s_addr0 = 17'h00005; s_wrdata0 = '0; s_wren0 = 1'b0; s_strobe0 = 1'b1;
    s_addr1 = '0; s_wrdata1 = '0; s_wren1 = 1'b0; s_strobe1 = 1'b0;

    // Reset held with strobe asserted.
    #23;
    chk("rst_wait", 32'(s_wait0), 32'd1);
    chk("rst_ce_n", 32'(ce_n0), 32'd1);
    chk("rst_oe_n", 32'(oe_n0), 32'd1);
    chk("rst_we_n", 32'(we_n0), 32'd1);
    chk("rst_dq_oe", 32'(dq_oe0), 32'd0);
    chk("rst_sram_a", 32'(sram_a0), 32'd0);
    chk("rst_dq_out", 32'(dq_out0), 32'd0);
    chk("rst_rddata", s_rddata0, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Read word 5 -> bytes 0x14..0x17, two OE_n-low cycles per byte.
    base = rd_trace.size();
    run_req(0, 1'b0, 17'h00005, 32'd0, 13, 32'h44332211);
    chk("rd_trace_len", 32'(rd_trace.size() - base), 32'd8);
    if (rd_trace.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) chk("rd_trace_a", 32'(rd_trace[base + i]), 32'h14 + 32'(i / 2));
    end

    // Write to the top word; rddata must keep the previous read.
    hbase = hold0;
    run_req(0, 1'b1, 17'h1FFFF, 32'hDEADBEEF, 17, 32'h44332211);
    wd = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) chk("wr_top_byte", 32'(mem0[19'h7FFFC + 19'(i)]), 32'(wd[8 * i +: 8]));
    chk("wr_hold_cycles", 32'(hold0 - hbase), 32'd4);

    // Back-to-back write then read of the same word.
    run_req(0, 1'b1, 17'h00010, 32'hCAFEF00D, 17, 32'h44332211);
    run_req(0, 1'b0, 17'h00010, 32'd0, 13, 32'hCAFEF00D);

    // Single-cycle access instance.
    run_req(1, 1'b0, 17'h00008, 32'd0, 9, 32'h04030201);
    run_req(1, 1'b1, 17'h00008, 32'h89ABCDEF, 13, 32'h04030201);
    run_req(1, 1'b0, 17'h00008, 32'd0, 9, 32'h89ABCDEF);

    // Reset during byte 2 Access of a write to word 3 (old bytes A0..A3).
    s_addr0 = 17'h00003; s_wrdata0 = 32'h55667788; s_wren0 = 1'b1; s_strobe0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_we_low", 32'(we_n0), 32'd0);
    chk("mid_sram_a", 32'(sram_a0), 32'h0000E);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(we_n0), 32'd1);
    chk("mid_rst_ce_n", 32'(ce_n0), 32'd1);
    chk("mid_rst_dq_oe", 32'(dq_oe0), 32'd0);
    chk("mid_rst_wait", 32'(s_wait0), 32'd1);
    s_strobe0 = 1'b0; s_wren0 = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rddata", s_rddata0, 32'd0);
    run_req(0, 1'b0, 17'h00003, 32'd0, 13, 32'hA3A27788);

    chk("dq_oe_oe_overlap0", 32'(ovl0), 32'd0);
    chk("dq_oe_oe_overlap1", 32'(ovl1), 32'd0);
    chk("we_during_read", 32'(rdwe), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
